// File: rtl/hub_nport.sv
// hub_nport: N-port serial broadcast hub.
//   Each port hunts for an 8-bit SFD on its rx line and then captures
//   DATA_WIDTH payload bits, LSB first. Each captured payload goes into that
//   port's FIFO. A round-robin scheduler takes one buffered word at a time and
//   retransmits it as SFD + payload on every tx line except the one the word
//   arrived on.
// Ports:
//   clk      system clock, one serial bit per cycle
//   reset    asynchronous, active-high
//   rx       [NUM_PORTS] serial receive lines
//   tx       [NUM_PORTS] serial transmit lines (registered)
//   rx_drop  [NUM_PORTS] one-cycle pulse when a frame is lost to a full FIFO
//   tx_busy  high while the scheduler is in PREAMBLE or PAYLOAD

// hub_port: per-port deframer plus payload FIFO.
//   rx_bit  serial input for this port
//   pop     scheduler takes the head word (only asserted when non-empty)
//   empty   FIFO holds no words
//   head    oldest buffered word
//   drop    registered pulse for a frame discarded on a full FIFO
module hub_port #(
   parameter int          DATA_WIDTH = 8,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [7:0]  SFD        = 8'b10101011
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx_bit,
   input  logic                  pop,
   output logic                  empty,
   output logic [DATA_WIDTH-1:0] head,
   output logic                  drop
);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int DCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic {HUNT, DATA} df_state_t;

   df_state_t             st, st_nx;
   // Only the 7 most recent bits are kept; the window compared against SFD
   // is those 7 bits plus the bit arriving this cycle.
   logic [6:0]            hunt, hunt_nx;
   logic [7:0]            win;
   logic [DATA_WIDTH-1:0] sh, sh_nx;
   logic [DCW-1:0]        cnt, cnt_nx;
   logic                  push;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st   <= HUNT;
         hunt <= '0;
         sh   <= '0;
         cnt  <= '0;
      end else begin
         st   <= st_nx;
         hunt <= hunt_nx;
         sh   <= sh_nx;
         cnt  <= cnt_nx;
      end
   end

   always_comb begin
      st_nx   = st;
      hunt_nx = hunt;
      sh_nx   = sh;
      cnt_nx  = cnt;
      push    = 1'b0;
      win     = {hunt, rx_bit};
      case (st)
         HUNT: begin
            hunt_nx = win[6:0];
            cnt_nx  = '0;
            if (win == SFD) st_nx = DATA;
         end
         DATA: begin
            // LSB first: each new bit enters at the top and moves down
            sh_nx  = DATA_WIDTH'({rx_bit, sh} >> 1);
            cnt_nx = cnt + DCW'(1);
            if (cnt == DCW'(DATA_WIDTH - 1)) begin
               push    = 1'b1;
               hunt_nx = '0;
               cnt_nx  = '0;
               st_nx   = HUNT;
            end
         end
         default: st_nx = HUNT;
      endcase
   end

   // FIFO with one extra pointer bit to tell full from empty
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW:0]           wp, rp;
   logic                  full, wr, rd;

   assign empty = (wp == rp);
   assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign rd    = pop && !empty;
   // A same-edge pop frees the slot, so a push to a full FIFO still lands
   assign wr    = push && (!full || rd);
   assign head  = mem[rp[AW-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wp   <= '0;
         rp   <= '0;
         drop <= 1'b0;
      end else begin
         if (wr) wp <= wp + (AW+1)'(1);
         if (rd) rp <= rp + (AW+1)'(1);
         drop <= push && !wr;
      end
   end

   always_ff @(posedge clk) begin
      if (wr) mem[wp[AW-1:0]] <= sh_nx;
   end
endmodule

module hub_nport #(
   parameter int          NUM_PORTS  = 2,
   parameter int          DATA_WIDTH = 8,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [7:0]  SFD        = 8'b10101011
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_PORTS-1:0] rx,
   output logic [NUM_PORTS-1:0] tx,
   output logic [NUM_PORTS-1:0] rx_drop,
   output logic                 tx_busy
);
   localparam int PW = $clog2(NUM_PORTS);
   // one counter serves the 8 preamble bits and the payload bits
   localparam int CW = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH) : 3;

   logic [NUM_PORTS-1:0]                 empty, pop;
   logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] head;

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
      hub_port #(
         .DATA_WIDTH (DATA_WIDTH),
         .FIFO_DEPTH (FIFO_DEPTH),
         .SFD        (SFD)
      ) u_port (
         .clk    (clk),
         .reset  (reset),
         .rx_bit (rx[i]),
         .pop    (pop[i]),
         .empty  (empty[i]),
         .head   (head[i]),
         .drop   (rx_drop[i])
      );
   end

   typedef enum logic [1:0] {IDLE, PRE, PAY} sch_state_t;

   sch_state_t           st, st_nx;
   logic [CW-1:0]        cnt, cnt_nx;
   logic [PW-1:0]        src, src_nx, rr_ptr, ptr_nx, sel;
   logic [DATA_WIDTH-1:0] wq, wq_nx;
   logic [NUM_PORTS-1:0] tx_nx, mask;
   logic                 found;
   int                   idx;

   // first non-empty port at or after rr_ptr, wrapping
   always_comb begin
      found = 1'b0;
      sel   = '0;
      idx   = 0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
         if (!found && !empty[PW'(idx)]) begin
            found = 1'b1;
            sel   = PW'(idx);
         end
      end
   end

   // the source port never hears its own frame
   assign mask    = ~(NUM_PORTS'(1) << src);
   assign tx_busy = (st != IDLE);

   always_comb begin
      st_nx  = st;
      cnt_nx = cnt;
      src_nx = src;
      ptr_nx = rr_ptr;
      wq_nx  = wq;
      tx_nx  = '0;
      pop    = '0;
      case (st)
         IDLE: begin
            if (found) begin
               pop    = NUM_PORTS'(1) << sel;
               src_nx = sel;
               wq_nx  = head[sel];
               cnt_nx = '0;
               st_nx  = PRE;
            end
         end
         PRE: begin
            tx_nx  = mask & {NUM_PORTS{SFD[3'd7 - cnt[2:0]]}};
            cnt_nx = cnt + CW'(1);
            if (cnt == CW'(7)) begin
               cnt_nx = '0;
               st_nx  = PAY;
            end
         end
         PAY: begin
            tx_nx  = mask & {NUM_PORTS{wq[0]}};
            wq_nx  = wq >> 1;
            cnt_nx = cnt + CW'(1);
            if (cnt == CW'(DATA_WIDTH - 1)) begin
               cnt_nx = '0;
               st_nx  = IDLE;
               ptr_nx = (src == PW'(NUM_PORTS - 1)) ? '0 : src + PW'(1);
            end
         end
         default: st_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st     <= IDLE;
         cnt    <= '0;
         src    <= '0;
         rr_ptr <= '0;
         wq     <= '0;
         tx     <= '0;
      end else begin
         st     <= st_nx;
         cnt    <= cnt_nx;
         src    <= src_nx;
         rr_ptr <= ptr_nx;
         wq     <= wq_nx;
         tx     <= tx_nx;
      end
   end
endmodule

// File: tb/tb_hub_nport.sv
// Directed bench for hub_nport. Two instances share clock and reset:
//   dut_a: 2 ports, FIFO depth 4 (defaults)
//   dut_b: 3 ports, FIFO depth 2
// Stimulus is laid out per cycle in arrays; outputs are logged per cycle at
// the falling edge and checked against hand-computed frame positions.
module tb_hub_nport;
   localparam int NC = 300;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] rx_a, tx_a, drop_a;
   logic       busy_a;
   logic [2:0] rx_b, tx_b, drop_b;
   logic       busy_b;

   always #5 clk = ~clk;

   hub_nport #(.NUM_PORTS(2)) dut_a (
      .clk(clk), .reset(reset), .rx(rx_a), .tx(tx_a), .rx_drop(drop_a), .tx_busy(busy_a)
   );
   hub_nport #(.NUM_PORTS(3), .FIFO_DEPTH(2)) dut_b (
      .clk(clk), .reset(reset), .rx(rx_b), .tx(tx_b), .rx_drop(drop_b), .tx_busy(busy_b)
   );

   logic [1:0] st_a [NC];
   logic [2:0] st_b [NC];
   logic [1:0] lt_a [NC];
   logic [1:0] ld_a [NC];
   logic       lb_a [NC];
   logic [2:0] lt_b [NC];
   logic [2:0] ld_b [NC];
   logic       lb_b [NC];

   int n_asrt = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr_stim();
      for (int c = 0; c < NC; c++) begin
         st_a[c] = '0;
         st_b[c] = '0;
      end
   endtask

   task automatic put_a(input int p, input int s, input logic [7:0] w);
      logic [7:0] sfd;
      sfd = 8'hAB;
      for (int i = 0; i < 8; i++) st_a[s+i][p] = sfd[7-i];
      for (int i = 0; i < 8; i++) st_a[s+8+i][p] = w[i];
   endtask

   task automatic put_b(input int p, input int s, input logic [7:0] w);
      logic [7:0] sfd;
      sfd = 8'hAB;
      for (int i = 0; i < 8; i++) st_b[s+i][p] = sfd[7-i];
      for (int i = 0; i < 8; i++) st_b[s+8+i][p] = w[i];
   endtask

   // apply stim[c] before edge c, log outputs after edge c
   task automatic run(input int n);
      for (int c = 0; c < n; c++) begin
         rx_a = st_a[c];
         rx_b = st_b[c];
         @(negedge clk);
         lt_a[c] = tx_a; ld_a[c] = drop_a; lb_a[c] = busy_a;
         lt_b[c] = tx_b; ld_b[c] = drop_b; lb_b[c] = busy_b;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      rx_a  = '0;
      rx_b  = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      clr_stim();
   endtask

   // wire image of a frame, first bit in the MSB
   function automatic logic [15:0] exp_frm(input logic [7:0] w);
      logic [15:0] r;
      r[15:8] = 8'hAB;
      for (int i = 0; i < 8; i++) r[7-i] = w[i];
      return r;
   endfunction

   function automatic logic [15:0] frm_a(input int p, input int s);
      logic [15:0] r;
      for (int i = 0; i < 16; i++) r[15-i] = lt_a[s+i][p];
      return r;
   endfunction

   function automatic logic [15:0] frm_b(input int p, input int s);
      logic [15:0] r;
      for (int i = 0; i < 16; i++) r[15-i] = lt_b[s+i][p];
      return r;
   endfunction

   function automatic int ones_a(input int p, input int s, input int e);
      int n = 0;
      for (int c = s; c <= e; c++) n += int'(lt_a[c][p]);
      return n;
   endfunction

   function automatic int ones_b(input int p, input int s, input int e);
      int n = 0;
      for (int c = s; c <= e; c++) n += int'(lt_b[c][p]);
      return n;
   endfunction

   function automatic int busy_cnt_a(input int s, input int e);
      int n = 0;
      for (int c = s; c <= e; c++) n += int'(lb_a[c]);
      return n;
   endfunction

   function automatic int busy_cnt_b(input int s, input int e);
      int n = 0;
      for (int c = s; c <= e; c++) n += int'(lb_b[c]);
      return n;
   endfunction

   function automatic int drops_a(input int p, input int s, input int e);
      int n = 0;
      for (int c = s; c <= e; c++) n += int'(ld_a[c][p]);
      return n;
   endfunction

   function automatic int drops_b(input int p, input int s, input int e);
      int n = 0;
      for (int c = s; c <= e; c++) n += int'(ld_b[c][p]);
      return n;
   endfunction

   // expected delivery order under overload (source port, frame index)
   int          t4_src [13] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 2, 0};
   int          t4_k   [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 3, 4, 5, 6, 7};
   int          d_port [11] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
   int          d_cyc  [11] = '{65, 97, 113, 65, 81, 113, 129, 49, 81, 97, 129};
   int          d_tot  [3]  = '{3, 4, 4};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] w;
      logic [8:0] pre;
      reset = 1'b1;
      rx_a  = '0;
      rx_b  = '0;
      @(negedge clk);
      chk("rst_tx_a",   tx_a,   2'b00);
      chk("rst_busy_a", busy_a, 1'b0);
      chk("rst_drop_b", drop_b, 3'b000);
      do_reset();
      chk("rst_tx_a2",   tx_a,   2'b00);
      chk("rst_drop_a2", drop_a, 2'b00);
      chk("rst_busy_a2", busy_a, 1'b0);
      chk("rst_tx_b2",   tx_b,   3'b000);
      chk("rst_drop_b2", drop_b, 3'b000);
      chk("rst_busy_b2", busy_b, 1'b0);

      // tests 1+2 on dut_a, test 3 on dut_b, in the same run
      put_a(0, 2, 8'hF0);
      put_a(1, 18, 8'hCC);
      put_b(0, 2, 8'h5A);
      put_b(2, 2, 8'h3C);
      run(60);
      chk("t1_tx1_frame",  frm_a(1, 19), exp_frm(8'hF0));
      chk("t1_tx1_early",  ones_a(1, 0, 18), 0);
      chk("t1_tx0_quiet",  ones_a(0, 0, 35), 0);
      chk("t1_busy_pre",   lb_a[17], 1'b0);
      chk("t1_busy_len",   busy_cnt_a(18, 33), 16);
      chk("t1_busy_end",   lb_a[34], 1'b0);
      chk("t2_gap",        lt_a[35], 2'b00);
      chk("t2_tx0_frame",  frm_a(0, 36), exp_frm(8'hCC));
      chk("t2_tx1_quiet",  ones_a(1, 35, 59), 0);
      chk("t2_tx0_after",  ones_a(0, 52, 59), 0);
      chk("t12_drop0",     drops_a(0, 0, 59), 0);
      chk("t12_drop1",     drops_a(1, 0, 59), 0);
      chk("t3_tx1_5a",     frm_b(1, 19), exp_frm(8'h5A));
      chk("t3_tx2_5a",     frm_b(2, 19), exp_frm(8'h5A));
      chk("t3_tx0_quiet",  ones_b(0, 0, 35), 0);
      chk("t3_gap",        lt_b[35], 3'b000);
      chk("t3_tx0_3c",     frm_b(0, 36), exp_frm(8'h3C));
      chk("t3_tx1_3c",     frm_b(1, 36), exp_frm(8'h3C));
      chk("t3_tx2_quiet",  ones_b(2, 36, 59), 0);
      chk("t3_ptr",        dut_b.rr_ptr, 0);

      // test 4: overload of dut_b, 8 back-to-back frames on every port
      do_reset();
      for (int p = 0; p < 3; p++)
         for (int k = 0; k < 8; k++)
            put_b(p, 2 + 16*k, {1'b0, 3'(k), 4'(p + 1)});
      run(260);
      for (int j = 0; j < 13; j++) begin
         w = {1'b0, 3'(t4_k[j]), 4'(t4_src[j] + 1)};
         for (int p = 0; p < 3; p++) begin
            if (p == t4_src[j])
               chk($sformatf("t4_f%0d_src%0d_quiet", j, p), ones_b(p, 19 + 17*j, 34 + 17*j), 0);
            else
               chk($sformatf("t4_f%0d_tx%0d", j, p), frm_b(p, 19 + 17*j), exp_frm(w));
         end
      end
      for (int p = 0; p < 3; p++) begin
         chk($sformatf("t4_tail_tx%0d", p), ones_b(p, 240, 259), 0);
         chk($sformatf("t4_drops%0d", p), drops_b(p, 0, 259), d_tot[p]);
      end
      for (int i = 0; i < 11; i++)
         chk($sformatf("t4_drop_p%0d_c%0d", d_port[i], d_cyc[i]), ld_b[d_cyc[i]][d_port[i]], 1'b1);
      chk("t4_busy_tail", busy_cnt_b(239, 259), 0);

      // test 5: reset during the 5th SFD bit with more words queued
      do_reset();
      put_a(0, 2, 8'h11);
      put_a(0, 18, 8'h22);
      put_a(0, 34, 8'h33);
      run(24);
      chk("t5_sfd_bit4", lt_a[22][1], 1'b0);
      chk("t5_sfd_bit5", lt_a[23][1], 1'b1);
      #2 reset = 1'b1;
      #1;
      chk("t5_async_tx",   tx_a,   2'b00);
      chk("t5_async_busy", busy_a, 1'b0);
      #1 reset = 1'b0;
      clr_stim();
      run(60);
      chk("t5_after_tx0",  ones_a(0, 0, 59), 0);
      chk("t5_after_tx1",  ones_a(1, 0, 59), 0);
      chk("t5_after_busy", busy_cnt_a(0, 59), 0);

      // test 6: near-miss pattern, then SFD preceded by an extra 1
      do_reset();
      for (int i = 0; i < 8; i++) st_a[2+i][0] = 1'(~i & 1);
      pre = 9'b110101011;
      for (int i = 0; i < 9; i++) st_a[40+i][0] = pre[8-i];
      w = 8'h81;
      for (int i = 0; i < 8; i++) st_a[49+i][0] = w[i];
      run(90);
      chk("t6_quiet_tx0", ones_a(0, 0, 89), 0);
      chk("t6_quiet_tx1", ones_a(1, 0, 57), 0);
      chk("t6_quiet_busy", busy_cnt_a(0, 56), 0);
      chk("t6_tx1_81",    frm_a(1, 58), exp_frm(8'h81));

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end
endmodule
